// File: rtl/packet_transmitter_if.sv
// ---------------------------------------------------------------------------
// packet_transmitter_if
//   Bundles the request-side and UART-side signals of packet_transmitter.
//
//   Modports:
//     master : the packet transmitter itself. It drives tx_valid, tx_data,
//              the three *_ready outputs and busy.
//     slave  : the surrounding logic. This is the DMA/execution requesters
//              plus the UART TX. It drives tx_ready and the request
//              valids and payloads.
//
//   Parameters:
//     TILE_W : write-tile width in bits (multiple of 8)
//     ADDR_W : memory address width (<= 16)
// ---------------------------------------------------------------------------
interface packet_transmitter_if #(
  parameter int TILE_W = 288,
  parameter int ADDR_W = 16
);
  // UART side
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;

  // Memory read request
  logic              mem_read_req_valid;
  logic              mem_read_req_ready;
  logic [ADDR_W-1:0] mem_read_req_addr;

  // Memory write request
  logic              mem_write_req_valid;
  logic              mem_write_req_ready;
  logic [ADDR_W-1:0] mem_write_req_addr;
  logic [TILE_W-1:0] mem_write_req_tile;

  // Program-done notice
  logic              program_done_valid;
  logic              program_done_ready;
  logic [7:0]        program_done_id;

  // Status
  logic              busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready,
    input  mem_read_req_valid, mem_read_req_addr,
    output mem_read_req_ready,
    input  mem_write_req_valid, mem_write_req_addr, mem_write_req_tile,
    output mem_write_req_ready,
    input  program_done_valid, program_done_id,
    output program_done_ready,
    output busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready,
    output mem_read_req_valid, mem_read_req_addr,
    input  mem_read_req_ready,
    output mem_write_req_valid, mem_write_req_addr, mem_write_req_tile,
    input  mem_write_req_ready,
    output program_done_valid, program_done_id,
    input  program_done_ready,
    input  busy
  );
endinterface

// File: rtl/packet_transmitter.sv
// ---------------------------------------------------------------------------
// packet_transmitter
//   Host-bound half of the byte-serial link. The module accepts one request
//   at a time: a memory read, a memory write or a program-done notice. It
//   turns the request into a packet and sends the packet one byte per
//   handshake into the UART transmitter.
//
//   Packet layout:
//     header byte  : [1:0] = type, [7:2] = payload length in bytes
//     payload      : sent MSB first
//     trailer byte : only with PACKET_TX_CHECKSUM_EN. It is the XOR of the
//                    header and all payload bytes.
//
//   Ports:
//     clk   : clock
//     reset : asynchronous, active-low reset
//     bus   : packet_transmitter_if.master. It carries these signals:
//               tx_valid/tx_ready/tx_data (UART side),
//               mem_read_req_*, mem_write_req_*, program_done_* (requesters),
//               busy.
//
//   Optional feature:
//     PACKET_TX_CHECKSUM_EN : when defined, a trailer byte is appended to
//                             every packet.
// ---------------------------------------------------------------------------
module packet_transmitter #(
  parameter int TILE_W = 288,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  packet_transmitter_if.master  bus
);

  localparam int TILE_B = TILE_W / 8;
`ifdef PACKET_TX_CHECKSUM_EN
  localparam int CK_B = 1;
`else
  localparam int CK_B = 0;
`endif
  // The longest packet is the write packet: header, 2 address bytes, the
  // tile and, optionally, the trailer.
  localparam int NB   = TILE_B + 3 + CK_B;
  localparam int SR_W = NB * 8;

  localparam logic [7:0] HDR_RD = 8'((2 << 2) | 1);
  localparam logic [7:0] HDR_WR = 8'(((TILE_B + 2) << 2) | 2);
  localparam logic [7:0] HDR_DN = 8'((1 << 2) | 3);

  localparam logic [6:0] CNT_RD = 7'(3 + CK_B);
  localparam logic [6:0] CNT_WR = 7'(TILE_B + 3 + CK_B);
  localparam logic [6:0] CNT_DN = 7'(2 + CK_B);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            state_q, state_d;
  logic              idle_q, idle_d;
  logic              tx_valid_q, tx_valid_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic [6:0]        cnt_q, cnt_d;

  logic              rd_acc, wr_acc, dn_acc, accept, hs;
  logic [15:0]       rd_addr16, wr_addr16;
  logic [SR_W-1:0]   rd_load, wr_load, dn_load;

  // The ready outputs use a fixed priority: read, then write, then done.
  // Because of the priority, at most one request is accepted per cycle.
  assign bus.mem_read_req_ready  = idle_q;
  assign bus.mem_write_req_ready = idle_q & ~bus.mem_read_req_valid;
  assign bus.program_done_ready  = idle_q & ~bus.mem_read_req_valid
                                          & ~bus.mem_write_req_valid;

  assign rd_acc = bus.mem_read_req_valid  & bus.mem_read_req_ready;
  assign wr_acc = bus.mem_write_req_valid & bus.mem_write_req_ready;
  assign dn_acc = bus.program_done_valid  & bus.program_done_ready;
  assign accept = rd_acc | wr_acc | dn_acc;

  assign hs = tx_valid_q & bus.tx_ready;

  // The address always takes 2 bytes on the wire. A narrower address is
  // zero-extended to 16 bits.
  assign rd_addr16 = 16'(bus.mem_read_req_addr);
  assign wr_addr16 = 16'(bus.mem_write_req_addr);

  // Each packet is loaded left-aligned, so the header sits in the top byte
  // of the shift register and leaves first.
`ifdef PACKET_TX_CHECKSUM_EN
  logic [7:0] tile_xor;
  logic [7:0] rd_ck, wr_ck, dn_ck;

  always_comb begin
    tile_xor = 8'h00;
    for (int i = 0; i < TILE_B; i++) begin
      tile_xor = tile_xor ^ bus.mem_write_req_tile[i*8 +: 8];
    end
  end

  assign rd_ck = HDR_RD ^ rd_addr16[15:8] ^ rd_addr16[7:0];
  assign wr_ck = HDR_WR ^ wr_addr16[15:8] ^ wr_addr16[7:0] ^ tile_xor;
  assign dn_ck = HDR_DN ^ bus.program_done_id;

  assign rd_load = {HDR_RD, rd_addr16, rd_ck, {(SR_W-32){1'b0}}};
  assign wr_load = {HDR_WR, wr_addr16, bus.mem_write_req_tile, wr_ck};
  assign dn_load = {HDR_DN, bus.program_done_id, dn_ck, {(SR_W-24){1'b0}}};
`else
  assign rd_load = {HDR_RD, rd_addr16, {(SR_W-24){1'b0}}};
  assign wr_load = {HDR_WR, wr_addr16, bus.mem_write_req_tile};
  assign dn_load = {HDR_DN, bus.program_done_id, {(SR_W-16){1'b0}}};
`endif

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_SEND;
          tx_valid_d = 1'b1;
          if (rd_acc) begin
            shift_d = rd_load;
            cnt_d   = CNT_RD;
          end else if (wr_acc) begin
            shift_d = wr_load;
            cnt_d   = CNT_WR;
          end else begin
            shift_d = dn_load;
            cnt_d   = CNT_DN;
          end
        end
      end
      S_SEND: begin
        if (hs) begin
          shift_d = {shift_q[SR_W-9:0], 8'h00};
          cnt_d   = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    // The idle flag re-arms one cycle after the last byte handshake. This
    // forces a one-cycle bubble between back-to-back packets. The flag also
    // comes up one cycle after reset release.
    idle_d = ~accept & (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idle_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      tx_valid_q <= tx_valid_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
    end
  end

  // tx_data is taken from the top byte of the shift register. Because it
  // is a register, the byte holds steady while the UART stalls.
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = shift_q[SR_W-1 -: 8];
  assign bus.busy     = (state_q == S_SEND);

endmodule

// File: tb/tb_packet_transmitter.sv
module tb_packet_transmitter;

  localparam int TILE_W = 288;
  localparam int ADDR_W = 16;
`ifdef PACKET_TX_CHECKSUM_EN
  localparam int CK_B = 1;
`else
  localparam int CK_B = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  packet_transmitter_if #(.TILE_W(TILE_W), .ADDR_W(ADDR_W)) bus ();

  packet_transmitter #(.TILE_W(TILE_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_x;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  logic [TILE_W-1:0] tile;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Record every byte that is handshaken, and check that tx_data holds
  // while tx_valid is high and tx_ready is low.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check_eq("stall_hold", bus.tx_data, prev_data);
      if (bus.tx_valid && bus.tx_ready) begin
        got_q.push_back(bus.tx_data);
        got_cyc.push_back(cyc);
        $display("byte %0d: 0x%02h at cycle %0d", got_q.size() - 1, bus.tx_data, cyc);
      end
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_start();
    exp_q.delete();
    exp_x = 8'h00;
  endtask

  task automatic exp_add(input logic [7:0] b);
    exp_q.push_back(b);
    exp_x = exp_x ^ b;
  endtask

  task automatic exp_end();
`ifdef PACKET_TX_CHECKSUM_EN
    exp_q.push_back(exp_x);
`endif
    exp_x = 8'h00;
  endtask

  task automatic compare_pkt(input string tag);
    check_eq({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        check_eq($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  task automatic wait_idle(input string tag, input int max, output int n);
    n = 0;
    while (bus.busy && n < max) begin
      tick();
      n++;
    end
    if (bus.busy) check_eq({tag, "_timeout"}, bus.busy, 1'b0);
  endtask

  task automatic send_read(input logic [15:0] addr);
    int n;
    n = 0;
    bus.mem_read_req_valid = 1'b1;
    bus.mem_read_req_addr  = addr;
    #1;
    while (!bus.mem_read_req_ready && n < 50) begin tick(); n++; end
    if (!bus.mem_read_req_ready) check_eq("rd_ready_timeout", bus.mem_read_req_ready, 1'b1);
    tick();
    bus.mem_read_req_valid = 1'b0;
    $display("read request accepted addr=0x%04h", addr);
  endtask

  task automatic send_write(input logic [15:0] addr, input logic [TILE_W-1:0] t);
    int n;
    n = 0;
    bus.mem_write_req_valid = 1'b1;
    bus.mem_write_req_addr  = addr;
    bus.mem_write_req_tile  = t;
    #1;
    while (!bus.mem_write_req_ready && n < 50) begin tick(); n++; end
    if (!bus.mem_write_req_ready) check_eq("wr_ready_timeout", bus.mem_write_req_ready, 1'b1);
    tick();
    bus.mem_write_req_valid = 1'b0;
    $display("write request accepted addr=0x%04h", addr);
  endtask

  task automatic send_done(input logic [7:0] id);
    int n;
    n = 0;
    bus.program_done_valid = 1'b1;
    bus.program_done_id    = id;
    #1;
    while (!bus.program_done_ready && n < 50) begin tick(); n++; end
    if (!bus.program_done_ready) check_eq("dn_ready_timeout", bus.program_done_ready, 1'b1);
    tick();
    bus.program_done_valid = 1'b0;
    $display("done notice accepted id=0x%02h", id);
  endtask

  task automatic exp_write_pkt();
    exp_add(8'h9A); exp_add(8'h00); exp_add(8'h01);
    for (int k = 0; k < 36; k++) exp_add(8'(k));
    exp_end();
  endtask

  initial begin
    int n;
    int acc;
    int acc_n;
    int t;
    logic r, w, d;

    bus.tx_ready            = 1'b0;
    bus.mem_read_req_valid  = 1'b0;
    bus.mem_read_req_addr   = '0;
    bus.mem_write_req_valid = 1'b0;
    bus.mem_write_req_addr  = '0;
    bus.mem_write_req_tile  = '0;
    bus.program_done_valid  = 1'b0;
    bus.program_done_id     = 8'h00;

    for (int k = 0; k < 36; k++) tile[TILE_W-1-8*k -: 8] = 8'(k);

    // Reset state
    repeat (3) tick();
    check_eq("rst_tx_valid", bus.tx_valid, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_tx_data", bus.tx_data, 8'h00);
    check_eq("rst_rd_ready", bus.mem_read_req_ready, 1'b0);
    check_eq("rst_wr_ready", bus.mem_write_req_ready, 1'b0);
    check_eq("rst_dn_ready", bus.program_done_ready, 1'b0);

    // Release: ready low on the first cycle, high from the second
    reset = 1'b1;
    #1;
    check_eq("rel_rd_ready_c1", bus.mem_read_req_ready, 1'b0);
    tick();
    check_eq("rel_rd_ready_c2", bus.mem_read_req_ready, 1'b1);
    check_eq("rel_wr_ready_c2", bus.mem_write_req_ready, 1'b1);
    check_eq("rel_dn_ready_c2", bus.program_done_ready, 1'b1);

    // Read request, tx_ready held high
    bus.tx_ready = 1'b1;
    got_q.delete(); got_cyc.delete();
    send_read(16'h1234);
    acc = cyc;
    bus.mem_read_req_addr = 16'hFFFF;
    check_eq("rd_first_valid", bus.tx_valid, 1'b1);
    check_eq("rd_first_data", bus.tx_data, 8'h09);
    check_eq("rd_busy", bus.busy, 1'b1);
    check_eq("rd_ready_in_send", bus.mem_read_req_ready, 1'b0);
    wait_idle("rd", 20, n);
    check_eq("rd_busy_cycles", n, 3 + CK_B);
    check_eq("rd_end_valid", bus.tx_valid, 1'b0);
    check_eq("rd_rearm", bus.mem_read_req_ready, 1'b1);
    exp_start(); exp_add(8'h09); exp_add(8'h12); exp_add(8'h34); exp_end();
    compare_pkt("rd");
    for (int i = 0; i < got_cyc.size(); i++)
      check_eq($sformatf("rd_cyc%0d", i), got_cyc[i], acc + i);

    // Write request
    got_q.delete(); got_cyc.delete();
    send_write(16'h0001, tile);
    wait_idle("wr", 100, n);
    check_eq("wr_busy_cycles", n, 39 + CK_B);
    exp_start(); exp_write_pkt();
    compare_pkt("wr");

    // Simultaneous read, write and done requests
    got_q.delete(); got_cyc.delete();
    bus.mem_read_req_valid  = 1'b1; bus.mem_read_req_addr  = 16'hBEEF;
    bus.mem_write_req_valid = 1'b1; bus.mem_write_req_addr = 16'h0001;
    bus.mem_write_req_tile  = tile;
    bus.program_done_valid  = 1'b1; bus.program_done_id    = 8'h5A;
    #1;
    check_eq("prio_rd_ready", bus.mem_read_req_ready, 1'b1);
    check_eq("prio_wr_ready", bus.mem_write_req_ready, 1'b0);
    check_eq("prio_dn_ready", bus.program_done_ready, 1'b0);
    acc_n = 0; t = 0;
    while (acc_n < 3 && t < 300) begin
      r = bus.mem_read_req_valid  & bus.mem_read_req_ready;
      w = bus.mem_write_req_valid & bus.mem_write_req_ready;
      d = bus.program_done_valid  & bus.program_done_ready;
      tick();
      t++;
      if (r) begin bus.mem_read_req_valid  = 1'b0; acc_n++; end
      if (w) begin bus.mem_write_req_valid = 1'b0; acc_n++; end
      if (d) begin bus.program_done_valid  = 1'b0; acc_n++; end
      #1;
    end
    check_eq("prio_accepts", acc_n, 3);
    wait_idle("prio", 100, n);
    exp_start();
    exp_add(8'h09); exp_add(8'hBE); exp_add(8'hEF); exp_end();
    exp_write_pkt();
    exp_add(8'h07); exp_add(8'h5A); exp_end();
    compare_pkt("prio");
    if (got_cyc.size() == exp_q.size()) begin
      check_eq("bubble_rd_wr", got_cyc[3+CK_B] - got_cyc[2+CK_B], 2);
      check_eq("bubble_wr_dn", got_cyc[42+2*CK_B] - got_cyc[41+2*CK_B], 2);
    end

    // Done packet with a stalling UART
    got_q.delete(); got_cyc.delete();
    bus.tx_ready = 1'b1;
    send_done(8'h3C);
    bus.tx_ready = 1'b0;
    tick();
    check_eq("stall_data_1", bus.tx_data, 8'h07);
    check_eq("stall_valid_1", bus.tx_valid, 1'b1);
    tick();
    check_eq("stall_data_2", bus.tx_data, 8'h07);
    t = 0;
    while (bus.busy && t < 50) begin
      bus.tx_ready = (t % 3 == 0);
      tick();
      t++;
    end
    check_eq("stall_end_busy", bus.busy, 1'b0);
    exp_start(); exp_add(8'h07); exp_add(8'h3C); exp_end();
    compare_pkt("stall");

    // Reset in the middle of a write packet
    got_q.delete(); got_cyc.delete();
    bus.tx_ready = 1'b1;
    send_write(16'h0001, tile);
    t = 0;
    while (got_q.size() < 10 && t < 100) begin tick(); t++; end
    reset = 1'b0;
    #1;
    check_eq("abort_tx_valid", bus.tx_valid, 1'b0);
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_tx_data", bus.tx_data, 8'h00);
    check_eq("abort_rd_ready", bus.mem_read_req_ready, 1'b0);
    repeat (3) tick();
    check_eq("abort_bytes", got_q.size(), 10);
    reset = 1'b1;
    got_q.delete(); got_cyc.delete();
    send_read(16'h00AB);
    check_eq("post_abort_hdr", bus.tx_data, 8'h09);
    wait_idle("post_abort", 20, n);
    exp_start(); exp_add(8'h09); exp_add(8'h00); exp_add(8'hAB); exp_end();
    compare_pkt("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
